// File: rtl/gray_srv_pkg.sv
// Shared constants and FSM state type for the gray frame server.
// Frame depth is a full power of two, so pixel addresses never go out of range.
package gray_srv_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        SERVE   = 2'd1,
        RELEASE = 2'd2
    } gray_srv_state_t;

endpackage

// File: rtl/gray_frame_ram.sv
// Frame store: DEPTH x DATA_W array, synchronous write, asynchronous read.
// Latency: write lands at the clock edge, read is combinational (0 cycles).
// Backpressure: none; the caller gates the write enable.
module gray_frame_ram
    import gray_srv_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents intentionally survive reset and frame re-arm.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gray_frame_server.sv
// Gray frame server: loads a 128x128 frame from a host stream, serves 0-latency reads to the LBP engine.
// Latency: 1 pixel/cycle load, 0-cycle read; ready flags decode the state register (glitch-free).
// Backpressure: load_ready low outside LOAD; optional GRAY_SRV_CHECKSUM_EN adds load_sum.
module gray_frame_server
    import gray_srv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              finish
`ifdef GRAY_SRV_CHECKSUM_EN
    ,
    output logic [15:0]       load_sum
`endif
);

    gray_srv_state_t   state;
    logic [ADDR_W-1:0] wr_cnt;
    logic              wr_en;
    logic [DATA_W-1:0] rd_dat;

    assign load_ready = (state == LOAD);
    assign gray_ready = (state == SERVE);
    assign wr_en      = load_valid & load_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= LOAD;
            wr_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_en) begin
                        // wr_cnt wraps to 0 on the last beat, ready for the next frame
                        wr_cnt <= wr_cnt + 1'b1;
                        if (&wr_cnt) begin
                            state <= SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (finish) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end

    gray_frame_ram u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_cnt),
        .wdata (load_data),
        .raddr (gray_addr),
        .rdata (rd_dat)
    );

    assign gray_data = (gray_ready && gray_req) ? rd_dat : '0;

`ifdef GRAY_SRV_CHECKSUM_EN
    // Cleared while in RELEASE so the sum reads 0 on entry to LOAD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_sum <= '0;
        end else if (state == RELEASE) begin
            load_sum <= '0;
        end else if (wr_en) begin
            load_sum <= load_sum + 16'(load_data);
        end
    end
`endif

endmodule

// File: tb/tb_gray_frame_server.sv
// Directed bench for gray_frame_server: reset, ramp/constant frame loads, serve reads, finish handshake, mid-load reset.
module tb_gray_frame_server;
    import gray_srv_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              finish;
`ifdef GRAY_SRV_CHECKSUM_EN
    logic [15:0]       load_sum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_frame_server dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .finish     (finish)
`ifdef GRAY_SRV_CHECKSUM_EN
        ,
        .load_sum   (load_sum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic req,
                      input logic [DATA_W-1:0] exp);
        gray_addr = a;
        gray_req  = req;
        #1;
        check(tag, gray_data, exp);
        step();
    endtask

    // kind 0: ramp i[7:0]; kind 1: 0x3C; kind 2: 0x11
    task automatic load_frame(input int n, input int kind, input bit gaps);
        int  i     = 0;
        int  guard = 0;
        bit  early = 0;
        bit  acc;
        while (i < n && guard < 60000) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (kind)
                0:       load_data = i[7:0];
                1:       load_data = 8'h3C;
                default: load_data = 8'h11;
            endcase
            acc = load_valid && load_ready;
            step();
            if (acc) i++;
            if (gray_ready && i < n) early = 1;
            guard++;
        end
        load_valid = 1'b0;
        check("load_beats_done", i, n);
        check("gray_ready_early", {31'd0, early}, 32'd0);
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        gray_req   = 1'b1;
        gray_addr  = '0;
        finish     = 1'b0;

        step();
        check("rst_load_ready", load_ready, 1);
        check("rst_gray_ready", gray_ready, 0);
        step();
        reset = 1'b1;
        step();
        check("post_rst_load_ready", load_ready, 1);
        check("post_rst_gray_ready", gray_ready, 0);
        check("post_rst_gray_data", gray_data, 8'h00);

        // Frame 1: ramp, continuous valid
        load_frame(DEPTH, 0, 1'b0);
        check("f1_gray_ready", gray_ready, 1);
        check("f1_load_ready", load_ready, 0);
        rd("f1_rd_0000", 14'h0000, 1'b1, 8'h00);
        rd("f1_rd_0081", 14'h0081, 1'b1, 8'h81);
        rd("f1_rd_3fff", 14'h3FFF, 1'b1, 8'hFF);
        rd("f1_noreq",   14'h0081, 1'b0, 8'h00);
`ifdef GRAY_SRV_CHECKSUM_EN
        check("f1_sum", load_sum, 16'hE000);
`endif

        // Host pushes while serving: must be ignored
        load_valid = 1'b1;
        load_data  = 8'hAA;
        for (int c = 0; c < 100; c++) step();
        load_valid = 1'b0;
        check("serve_still_ready", gray_ready, 1);
        rd("serve_rd_5", 14'h0005, 1'b1, 8'h05);
        rd("serve_rd_0", 14'h0000, 1'b1, 8'h00);
`ifdef GRAY_SRV_CHECKSUM_EN
        check("serve_sum_stable", load_sum, 16'hE000);
`endif

        // finish at edge k: gray_ready drops at k+1, load_ready rises at k+2
        gray_req  = 1'b1;
        gray_addr = 14'h0005;
        pulse_finish();
        check("rel_gray_ready", gray_ready, 0);
        check("rel_load_ready", load_ready, 0);
        check("rel_gray_data", gray_data, 8'h00);
        step();
        check("rearm_load_ready", load_ready, 1);
        check("rearm_gray_ready", gray_ready, 0);
`ifdef GRAY_SRV_CHECKSUM_EN
        check("rearm_sum_clear", load_sum, 16'h0000);
`endif

        // Frame 2: constant 0x3C
        load_frame(DEPTH, 1, 1'b0);
        check("f2_gray_ready", gray_ready, 1);
        rd("f2_rd_0000", 14'h0000, 1'b1, 8'h3C);
        rd("f2_rd_0081", 14'h0081, 1'b1, 8'h3C);
        rd("f2_rd_1234", 14'h1234, 1'b1, 8'h3C);
        rd("f2_rd_3fff", 14'h3FFF, 1'b1, 8'h3C);
`ifdef GRAY_SRV_CHECKSUM_EN
        check("f2_sum", load_sum, 16'h0000);
`endif

        pulse_finish();
        step();
        check("f2_rearm", load_ready, 1);

        // Partial load then reset mid-frame
        load_frame(5000, 2, 1'b0);
        check("partial_no_ready", gray_ready, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_state", 32'(dut.state), 32'(LOAD));
        check("midrst_wr_cnt", 32'(dut.wr_cnt), 32'd0);
        check("midrst_load_ready", load_ready, 1);
        check("midrst_gray_ready", gray_ready, 0);

        // Frame 3: ramp with random valid gaps, must start from address 0
        load_frame(DEPTH, 0, 1'b1);
        check("f3_gray_ready", gray_ready, 1);
        rd("f3_rd_0000", 14'h0000, 1'b1, 8'h00);
        rd("f3_rd_1387", 14'd4999, 1'b1, 8'h87);
        rd("f3_rd_1388", 14'd5000, 1'b1, 8'h88);
        rd("f3_rd_3fff", 14'h3FFF, 1'b1, 8'hFF);
`ifdef GRAY_SRV_CHECKSUM_EN
        check("f3_sum_gaps", load_sum, 16'hE000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
